ex_muldiv_seq: RTL and testbench

// - Iterative sequencer for the RV32M multiply/divide ops; sits beside the execute-stage ALU.
// - Accepts one op while the M-instruction occupies EX, and stalls EX until the op completes.
// - Delivers the 32-bit result that EX selects in place of the ALU output.
// - Magnitude-based unsigned shift-add / restoring-divide engine; sign fixup on completion.

---
 rtl/ex_muldiv_seq_pkg.sv | 37 +++
 rtl/ex_muldiv_seq_if.sv | 27 ++
 rtl/ex_muldiv_seq.sv | 170 +++++++++++++++++
 tb/tb_ex_muldiv_seq.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_seq_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package ex_muldiv_seq_pkg;

    localparam int MULDIV_XLEN  = 32;
    localparam int MULDIV_ITERS = 32;
    localparam int MULDIV_CNT_W = $clog2(MULDIV_ITERS) + 1;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_t;

    function automatic logic op_is_div(muldiv_op_t op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic op_is_rem(muldiv_op_t op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    // rs1 is interpreted as signed by every op except the fully unsigned ones
    function automatic logic op_a_signed(muldiv_op_t op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    // rs2 is unsigned for MULHSU as well as the *U ops
    function automatic logic op_b_signed(muldiv_op_t op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/ex_muldiv_seq_if.sv
// Execute-stage handshake between EX and the multiply/divide sequencer.
interface ex_muldiv_seq_if;
    import ex_muldiv_seq_pkg::*;

    logic                   i_start;
    muldiv_op_t             i_op;
    logic [MULDIV_XLEN-1:0] i_a;
    logic [MULDIV_XLEN-1:0] i_b;
    logic                   i_hold;
    logic                   i_flush;
    logic                   o_stall;
    logic                   o_done;
    logic [MULDIV_XLEN-1:0] o_result;

    // EX side drives the op and consumes the stall/result
    modport master (
        output i_start, i_op, i_a, i_b, i_hold, i_flush,
        input  o_stall, o_done, o_result
    );

    // sequencer side
    modport slave (
        input  i_start, i_op, i_a, i_b, i_hold, i_flush,
        output o_stall, o_done, o_result
    );

endinterface

// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M sequencer: magnitude shift-add multiply and restoring
// divide, one step per cycle, with sign fixup folded into the final step.
module ex_muldiv_seq
    import ex_muldiv_seq_pkg::*;
#(
    parameter int XLEN  = MULDIV_XLEN,
    parameter int ITERS = MULDIV_ITERS
) (
    input  logic           clk,
    input  logic           rst_n,
    ex_muldiv_seq_if.slave bus
);

    localparam int CNT_W = $clog2(ITERS) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    muldiv_op_t        op_q;
    logic [XLEN-1:0]   b_mag;
    logic              res_neg;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   result_q;

    logic              a_sign;
    logic              b_sign;
    logic [XLEN-1:0]   a_abs;
    logic [XLEN-1:0]   b_abs;
    logic              is_special;
    logic [XLEN-1:0]   special_result;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] acc_step;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   final_result;

    // Decode incoming operands: masked sign bits, magnitudes and fixed-result cases
    always_comb begin
        logic b_zero;
        logic ovf;
        a_sign = bus.i_a[XLEN-1] & op_a_signed(bus.i_op);
        b_sign = bus.i_b[XLEN-1] & op_b_signed(bus.i_op);
        a_abs  = a_sign ? -bus.i_a : bus.i_a;
        b_abs  = b_sign ? -bus.i_b : bus.i_b;
        b_zero = (bus.i_b == '0);
        ovf    = (bus.i_op inside {OP_DIV, OP_REM}) &&
                 (bus.i_a == INT_MIN) && (bus.i_b == '1);
        is_special = op_is_div(bus.i_op) && (b_zero || ovf);
        special_result = '0;
        if (b_zero) begin
            special_result = op_is_rem(bus.i_op) ? bus.i_a : '1;
        end else begin
            special_result = op_is_rem(bus.i_op) ? '0 : INT_MIN;
        end
    end

    // One iteration of the engine plus the sign-corrected result it would yield
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? b_mag : '0)};
        div_diff = acc[2*XLEN-1:XLEN-1] - {1'b0, b_mag};
        acc_step = '0;
        if (op_is_div(op_q)) begin
            if (div_diff[XLEN]) begin
                acc_step = {acc[2*XLEN-2:0], 1'b0};
            end else begin
                acc_step = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end
        end else begin
            acc_step = {mul_sum, acc[XLEN-1:1]};
        end

        prod_fix = res_neg ? -acc_step : acc_step;
        quo      = acc_step[XLEN-1:0];
        rem      = acc_step[2*XLEN-1:XLEN];
        final_result = '0;
        case (op_q)
            OP_MUL:                       final_result = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_result = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              final_result = res_neg ? -quo : quo;
            OP_REM, OP_REMU:              final_result = res_neg ? -rem : rem;
            default:                      final_result = '0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and EX-facing handshake; flush beats start and hold
    always_comb begin
        state_next  = state;
        bus.o_stall = bus.i_start & (state != ST_DONE);
        bus.o_done  = (state == ST_DONE);
        case (state)
            ST_IDLE: begin
                if (bus.i_start) begin
                    state_next = is_special ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (cnt == CNT_LAST) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!bus.i_hold) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (bus.i_flush) begin
            state_next = ST_IDLE;
        end
    end

    // Operand latch, iteration datapath and registered result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            op_q     <= OP_MUL;
            b_mag    <= '0;
            res_neg  <= 1'b0;
            acc      <= '0;
            result_q <= '0;
        end else if (!bus.i_flush) begin
            case (state)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        op_q    <= bus.i_op;
                        b_mag   <= b_abs;
                        res_neg <= op_is_rem(bus.i_op) ? a_sign : (a_sign ^ b_sign);
                        acc     <= {{XLEN{1'b0}}, a_abs};
                        cnt     <= '0;
                        if (is_special) begin
                            result_q <= special_result;
                        end
                    end
                end
                ST_CALC: begin
                    acc <= acc_step;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        result_q <= final_result;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_result = result_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Self-checking bench for ex_muldiv_seq: vector table plus hand sequences
// for flush, hold and mid-op reset, with a queue-based result scoreboard.
module tb_ex_muldiv_seq;
    import ex_muldiv_seq_pkg::*;

    typedef struct {
        muldiv_op_t  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    logic        clk;
    logic        rst_n;
    int          compared;
    int          mismatched;
    logic [31:0] expQ[$];
    vec_t        vecs[$];
    logic [31:0] lastResult;

    ex_muldiv_seq_if bus();

    ex_muldiv_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guard against a hung run
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h", name, actual, expected);
        end
    endtask

    // Drive one op, scramble operands after acceptance, wait for o_done
    task automatic applyStimulus(input muldiv_op_t op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] expRes,
                                 input int expLat, input int holdN, input string name);
        int          cyc;
        int          stallCycles;
        bit          seen;
        logic [31:0] expv;
        bus.i_start = 1'b1;
        bus.i_op    = op;
        bus.i_a     = a;
        bus.i_b     = b;
        expQ.push_back(expRes);
        cyc         = 0;
        stallCycles = 0;
        seen        = 1'b0;
        while (!seen && cyc <= 40) begin
            @(negedge clk);
            if (bus.o_done) begin
                seen = 1'b1;
            end else begin
                if (bus.o_stall) stallCycles++;
                @(posedge clk);
                #1;
                cyc++;
                bus.i_a  = $urandom;
                bus.i_b  = $urandom;
                bus.i_op = muldiv_op_t'($urandom_range(0, 7));
            end
        end
        if (seen) begin
            expv = expQ.pop_front();
            checkOutput({name, "_result"}, bus.o_result, expv);
            checkOutput({name, "_latency"}, 32'(cyc), 32'(expLat));
            checkOutput({name, "_stallcycles"}, 32'(stallCycles), 32'(expLat));
            checkOutput({name, "_stallindone"}, {31'b0, bus.o_stall}, 32'd0);
            if (holdN > 0) begin
                bus.i_hold = 1'b1;
                for (int h = 0; h < holdN; h++) begin
                    @(posedge clk);
                    #1;
                    @(negedge clk);
                    checkOutput($sformatf("%s_hold%0d_done", name, h), {31'b0, bus.o_done}, 32'd1);
                    checkOutput($sformatf("%s_hold%0d_result", name, h), bus.o_result, expv);
                end
                bus.i_hold = 1'b0;
            end
            lastResult = expv;
        end else begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s_timeout: no o_done within 40 cycles, wanted latency %0d", name, expLat);
            void'(expQ.pop_front());
        end
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
    endtask

    initial begin
        int doneSeen;
        compared    = 0;
        mismatched  = 0;
        lastResult  = '0;
        rst_n       = 1'b0;
        bus.i_start = 1'b0;
        bus.i_op    = OP_MUL;
        bus.i_a     = '0;
        bus.i_b     = '0;
        bus.i_hold  = 1'b0;
        bus.i_flush = 1'b0;

        vecs.push_back('{OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33});
        vecs.push_back('{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33});
        vecs.push_back('{OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33});
        vecs.push_back('{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
        vecs.push_back('{OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1});
        vecs.push_back('{OP_REM,    32'd5,        32'd0,        32'd5,        1});
        vecs.push_back('{OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33});
        vecs.push_back('{OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33});
        vecs.push_back('{OP_REMU,   32'hFFFFFFF9, 32'd2,        32'd1,        33});
        vecs.push_back('{OP_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33});
        vecs.push_back('{OP_MULHSU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33});
        vecs.push_back('{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33});
        vecs.push_back('{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1});
        vecs.push_back('{OP_REM,    32'd20,       32'hFFFFFFFD, 32'd2,        33});
        vecs.push_back('{OP_DIVU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33});
        vecs.push_back('{OP_REMU,   32'd7,        32'd0,        32'd7,        1});
        vecs.push_back('{OP_MUL,    32'h12345678, 32'h10,       32'h23456780, 33});
        vecs.push_back('{OP_DIV,    32'd0,        32'd5,        32'd0,        33});

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_done",   {31'b0, bus.o_done},  32'd0);
        checkOutput("reset_stall",  {31'b0, bus.o_stall}, 32'd0);
        checkOutput("reset_result", bus.o_result,         32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
                          vecs[i].lat, 0, $sformatf("vec%0d", i));
        end

        // Flush at CALC cycle 10: op is dropped, no o_done, result held
        bus.i_start = 1'b1;
        bus.i_op    = OP_MUL;
        bus.i_a     = 32'd123;
        bus.i_b     = 32'd456;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        bus.i_flush = 1'b1;
        bus.i_start = 1'b0;
        @(posedge clk);
        #1;
        bus.i_flush = 1'b0;
        @(negedge clk);
        checkOutput("flush_done",  {31'b0, bus.o_done},  32'd0);
        checkOutput("flush_stall", {31'b0, bus.o_stall}, 32'd0);
        doneSeen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.o_done) doneSeen++;
        end
        checkOutput("flush_nodone", 32'(doneSeen), 32'd0);
        checkOutput("flush_resultheld", bus.o_result, lastResult);
        @(posedge clk);
        #1;
        applyStimulus(OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 0, "postflush");

        // Hold in DONE for three extra cycles
        applyStimulus(OP_DIV, 32'd20, 32'hFFFFFFFD, 32'hFFFFFFFA, 33, 3, "hold");
        @(negedge clk);
        checkOutput("hold_release_done", {31'b0, bus.o_done}, 32'd0);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of CALC
        bus.i_start = 1'b1;
        bus.i_op    = OP_MUL;
        bus.i_a     = 32'h1234;
        bus.i_b     = 32'h5678;
        repeat (15) begin
            @(posedge clk);
            #1;
        end
        rst_n       = 1'b0;
        bus.i_start = 1'b0;
        #1;
        checkOutput("midreset_done",   {31'b0, bus.o_done},  32'd0);
        checkOutput("midreset_stall",  {31'b0, bus.o_stall}, 32'd0);
        checkOutput("midreset_result", bus.o_result,         32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(OP_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, 0, "postreset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
